// File: rtl/alu_pkg.sv
// Shared encodings for alu_seq: default width, opcodes and FSM states.
// ALU_SEQ_DIV_EN selects whether DIV/DIVU are implemented (see alu_seq).
package alu_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [3:0] {
        A_NOP   = 4'd0,
        A_ADD   = 4'd1,
        A_SUB   = 4'd2,
        A_AND   = 4'd3,
        A_OR    = 4'd4,
        A_XOR   = 4'd5,
        A_SLL   = 4'd6,
        A_SRL   = 4'd7,
        A_SRA   = 4'd8,
        A_LUI   = 4'd9,
        A_MULT  = 4'd10,
        A_MULTU = 4'd11,
        A_DIV   = 4'd12,
        A_DIVU  = 4'd13
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_seq_md.sv
// Iterative magnitude datapath: shift-add multiplier and, with ALU_SEQ_DIV_EN,
// a restoring divider sharing one 2*WIDTH accumulator. One bit per cycle.
module alu_seq_md
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   ma,
    input  logic [WIDTH-1:0]   mb,
    output logic [2*WIDTH-1:0] acc,
    output logic               done
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   opb;
    logic               busy;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] acc_nxt;

`ifdef ALU_SEQ_DIV_EN
    logic           div_q;
    logic [WIDTH:0] sub_diff;
`else
    logic unused_div;
    assign unused_div = is_div;
`endif

    assign done = busy && (cnt == CW'(WIDTH - 1));

    always_comb begin
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        acc_nxt = {add_sum, acc[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
        // Restoring step: trial-subtract divisor from the shifted partial remainder.
        sub_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
        if (div_q)
            acc_nxt = sub_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            opb  <= '0;
            busy <= 1'b0;
            cnt  <= '0;
`ifdef ALU_SEQ_DIV_EN
            div_q <= 1'b0;
`endif
        end else if (start) begin
            acc  <= {{WIDTH{1'b0}}, ma};
            opb  <= mb;
            busy <= 1'b1;
            cnt  <= '0;
`ifdef ALU_SEQ_DIV_EN
            div_q <= is_div;
`endif
        end else if (busy) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered EX-stage ALU with iterative MULT/MULTU and optional DIV/DIVU.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise DIV/DIVU complete as NOP.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_W,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] hi,
    output logic             z
);

    state_t             state, state_nxt;
    logic               accept, md_op, sgn_in, is_div_in, md_done;
    logic [WIDTH-1:0]   base_f, ma, mb, fix_f, fix_hi;
    logic [2*WIDTH-1:0] md_acc, prod;
    logic [3:0]         op_q;
    logic               neg_a, neg_b;
`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH-1:0]   a_q;
    logic               b_zero;
`endif

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        md_op     = (op == A_MULT) || (op == A_MULTU);
        is_div_in = 1'b0;
`ifdef ALU_SEQ_DIV_EN
        is_div_in = (op == A_DIV) || (op == A_DIVU);
        md_op     = md_op || is_div_in;
`endif
        sgn_in = (op == A_MULT) || (op == A_DIV);
        ma     = (sgn_in && a[WIDTH-1]) ? -a : a;
        mb     = (sgn_in && b[WIDTH-1]) ? -b : b;
    end

    always_comb begin
        base_f = '0;
        case (op)
            A_ADD:   base_f = a + b;
            A_SUB:   base_f = a - b;
            A_AND:   base_f = a & b;
            A_OR:    base_f = a | b;
            A_XOR:   base_f = a ^ b;
            A_SLL:   base_f = b << a[SHAMT_W-1:0];
            A_SRL:   base_f = b >> a[SHAMT_W-1:0];
            A_SRA:   base_f = $signed(b) >>> a[SHAMT_W-1:0];
            A_LUI:   base_f = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default: base_f = '0;
        endcase
    end

    alu_seq_md #(.WIDTH(WIDTH)) u_md (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && md_op),
        .is_div (is_div_in),
        .ma     (ma),
        .mb     (mb),
        .acc    (md_acc),
        .done   (md_done)
    );

    // Sign correction: the datapath only ever sees magnitudes.
    always_comb begin
        prod           = (op_q == A_MULT && (neg_a ^ neg_b)) ? -md_acc : md_acc;
        {fix_hi, fix_f} = prod;
`ifdef ALU_SEQ_DIV_EN
        if (op_q == A_DIV || op_q == A_DIVU) begin
            if (b_zero) begin
                fix_f  = '1;
                fix_hi = a_q;
            end else begin
                fix_f  = (neg_a ^ neg_b) ? -md_acc[WIDTH-1:0] : md_acc[WIDTH-1:0];
                fix_hi = neg_a ? -md_acc[2*WIDTH-1:WIDTH] : md_acc[2*WIDTH-1:WIDTH];
            end
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = md_op ? S_CALC : S_DONE;
            S_CALC: if (md_done) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            f     <= '0;
            hi    <= '0;
            z     <= 1'b1;
            op_q  <= 4'd0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            a_q    <= '0;
            b_zero <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q  <= op;
                neg_a <= sgn_in && a[WIDTH-1];
                neg_b <= sgn_in && b[WIDTH-1];
`ifdef ALU_SEQ_DIV_EN
                a_q    <= a;
                b_zero <= (b == '0);
`endif
                if (!md_op) begin
                    f  <= base_f;
                    hi <= '0;
                    z  <= (base_f == '0);
                end
            end
            if (state == S_FIX) begin
                f  <= fix_f;
                hi <= fix_hi;
                z  <= (fix_f == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32); DIV expectations follow ALU_SEQ_DIV_EN.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, z;
    logic [31:0] a, b, f, hi;
    logic [3:0]  op;
    int          n_chk = 0;
    int          n_err = 0;

    alu_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .hi        (hi),
        .z         (z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op from IDLE and wait (bounded) for its result; leaves the bench in DONE.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] xa,
                          input logic [31:0] xb, input logic [31:0] ef, input logic [31:0] eh,
                          input int elat);
        int lat;
        chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = o; a = xa; b = xb;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 4'(A_ADD); a = $urandom; b = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".lat"}, 32'(lat), 32'(elat));
        chk({tag, ".f"}, f, ef);
        chk({tag, ".hi"}, hi, eh);
        chk({tag, ".z"}, 32'(z), 32'(ef == 32'd0));
    endtask

    task automatic op_ret(input string tag, input logic [3:0] o, input logic [31:0] xa,
                          input logic [31:0] xb, input logic [31:0] ef, input logic [31:0] eh,
                          input int elat);
        run_op(tag, o, xa, xb, ef, eh, elat);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.f", f, 32'd0);
        chk("rst.hi", hi, 32'd0);
        chk("rst.z", 32'(z), 32'd1);
        rst = 1'b0;

        op_ret("add_wrap", 4'(A_ADD), 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1);
        op_ret("sra", 4'(A_SRA), 32'd4, 32'h8000_0000, 32'hF800_0000, 32'd0, 1);
        op_ret("srl", 4'(A_SRL), 32'd4, 32'h8000_0000, 32'h0800_0000, 32'd0, 1);
        op_ret("sub", 4'(A_SUB), 32'd5, 32'd7, 32'hFFFF_FFFE, 32'd0, 1);
        op_ret("sll", 4'(A_SLL), 32'd35, 32'd1, 32'd8, 32'd0, 1);
        op_ret("lui", 4'(A_LUI), 32'd0, 32'h1234_ABCD, 32'hABCD_0000, 32'd0, 1);
        op_ret("and", 4'(A_AND), 32'hF0F0, 32'hFF00, 32'hF000, 32'd0, 1);
        op_ret("or", 4'(A_OR), 32'hF0F0, 32'h0F00, 32'hFFF0, 32'd0, 1);

        op_ret("mult", 4'(A_MULT), 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 34);
        op_ret("multu", 4'(A_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 34);
        op_ret("mult_nn", 4'(A_MULT), 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd30, 32'd0, 34);
        op_ret("op15", 4'd15, 32'd3, 32'd4, 32'd0, 32'd0, 1);

`ifdef ALU_SEQ_DIV_EN
        op_ret("div", 4'(A_DIV), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
        op_ret("divu_z", 4'(A_DIVU), 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 34);
        op_ret("div_ovf", 4'(A_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 34);
        op_ret("divu", 4'(A_DIVU), 32'd100, 32'd7, 32'd14, 32'd2, 34);
        op_ret("div_z", 4'(A_DIV), 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 34);
`else
        op_ret("div_off", 4'(A_DIV), 32'd8, 32'd2, 32'd0, 32'd0, 1);
        op_ret("divu_off", 4'(A_DIVU), 32'd9, 32'd3, 32'd0, 32'd0, 1);
`endif

        // Backpressure: result must hold and nothing new may be accepted.
        out_ready = 1'b0;
        run_op("bp", 4'(A_ADD), 32'd2, 32'd3, 32'd5, 32'd0, 1);
        in_valid = 1'b1; op = 4'(A_XOR); a = 32'hF0; b = 32'hFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp.hold_valid", 32'(out_valid), 32'd1);
            chk("bp.hold_f", f, 32'd5);
            chk("bp.in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.retired", 32'(out_valid), 32'd0);
        chk("bp.idle_rdy", 32'(in_ready), 32'd1);
        chk("bp.f_kept", f, 32'd5);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp.next_valid", 32'(out_valid), 32'd1);
        chk("bp.next_f", f, 32'h0F);
        @(posedge clk); #1;

        // Reset during CALC aborts the multiply.
        in_valid = 1'b1; op = 4'(A_MULT); a = 32'd123; b = 32'd456;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort.busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort.out_valid", 32'(out_valid), 32'd0);
        chk("abort.in_ready", 32'(in_ready), 32'd1);
        chk("abort.f", f, 32'd0);
        chk("abort.z", 32'(z), 32'd1);
        op_ret("after_abort", 4'(A_MULTU), 32'd6, 32'd7, 32'd42, 32'd0, 34);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
